// File: rtl/fix2float_pkg.sv
// Shared constants and FSM state type for the fixed-to-FP32 converter.
// Rounding mode is selected by FIX2FLT_RNE_EN.
package fix2float_pkg;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_EXP_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } f2f_state_t;

endpackage

// File: rtl/fix2float_round.sv
// Mantissa rounding stage: RNE with FIX2FLT_RNE_EN defined, else truncation.
// A mantissa carry-out bumps the exponent and leaves a zero mantissa.
module fix2float_round
  import fix2float_pkg::*;
(
  input  logic [FP32_MANT_W-1:0] mant_i,
  input  logic                   guard_i,
  input  logic                   sticky_i,
  input  logic [FP32_EXP_W-1:0]  exp_i,
  output logic [FP32_MANT_W-1:0] mant_o,
  output logic [FP32_EXP_W-1:0]  exp_o
);

`ifdef FIX2FLT_RNE_EN
  logic                 up;
  logic [FP32_MANT_W:0] sum;

  assign up  = guard_i & (sticky_i | mant_i[0]);
  assign sum = {1'b0, mant_i} + {{FP32_MANT_W{1'b0}}, up};

  // On carry the low bits of sum are already zero.
  assign mant_o = sum[FP32_MANT_W-1:0];
  assign exp_o  = exp_i
                + {{(FP32_EXP_W-1){1'b0}}, sum[FP32_MANT_W]};
`else
  logic unused_gs;

  assign unused_gs = guard_i ^ sticky_i;
  assign mant_o    = mant_i;
  assign exp_o     = exp_i;
`endif

endmodule

// File: rtl/fix2float32_seq.sv
// Sequential signed fixed-point to FP32 converter, 1-bit/cycle normaliser.
// FIX2FLT_RNE_EN selects round-to-nearest-even instead of truncation.
module fix2float32_seq
  import fix2float_pkg::*;
#(
  parameter int NUM_OF_INT  = 8,
  parameter int NUM_OF_FRAC = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_OF_INT-1:0]  IN_int,
  input  logic [NUM_OF_FRAC-1:0] IN_frac,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            OUT_FLOAT32
);

  localparam int W  = NUM_OF_INT + NUM_OF_FRAC;
  localparam int EW = (W < 26) ? 26 : W;
  localparam logic [FP32_EXP_W-1:0] EXP0 =
    FP32_EXP_W'(W - 1 - NUM_OF_FRAC + FP32_BIAS);

  if (NUM_OF_FRAC != 23) begin : g_frac_chk
    $error("fix2float32_seq: NUM_OF_FRAC must be 23");
  end
  if (NUM_OF_INT < 1 || NUM_OF_INT > 8) begin : g_int_chk
    $error("fix2float32_seq: NUM_OF_INT must be 1..8");
  end

  f2f_state_t state_q;

  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   sign_q;
  logic [W-1:0]           mag_q;
  logic [FP32_EXP_W-1:0]  exp_q;
  logic [31:0]            out_q;

  logic [W-1:0]           x;
  logic [EW-1:0]          ext;
  logic [FP32_MANT_W-1:0] mant_c;
  logic                   guard_c;
  logic                   sticky_c;
  logic [FP32_MANT_W-1:0] mant_r;
  logic [FP32_EXP_W-1:0]  exp_r;
  logic                   unused_lead;

  assign x = {IN_int, IN_frac};

  // Zero-pad below the LSB so guard/sticky exist for narrow W.
  assign ext         = EW'(mag_q) << (EW - W);
  assign mant_c      = ext[EW-2 -: FP32_MANT_W];
  assign guard_c     = ext[EW-25];
  assign sticky_c    = |ext[EW-26:0];
  assign unused_lead = ext[EW-1];

  fix2float_round u_round (
    .mant_i   (mant_c),
    .guard_i  (guard_c),
    .sticky_i (sticky_c),
    .exp_i    (exp_q),
    .mant_o   (mant_r),
    .exp_o    (exp_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      out_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= x[W-1];
            mag_q      <= x[W-1] ? -x : x;
            exp_q      <= EXP0;
            in_ready_q <= 1'b0;
            state_q    <= NORM;
          end
        end
        NORM: begin
          if (mag_q == '0 || mag_q[W-1]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= {mag_q[W-2:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        ROUND: begin
          // A clear MSB after NORM means the sample was zero.
          out_q       <= mag_q[W-1] ? {sign_q, exp_r, mant_r}
                                    : 32'h0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign OUT_FLOAT32 = out_q;

endmodule

// File: tb/tb_fix2float32_seq.sv
// Directed bench for fix2float32_seq (W=31), expectations follow
// FIX2FLT_RNE_EN for the rounding-sensitive vectors.
module tb_fix2float32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  IN_int = '0;
  logic [22:0] IN_frac = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] OUT_FLOAT32;

  int checks = 0;
  int failures = 0;

  fix2float32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .IN_int      (IN_int),
    .IN_frac     (IN_frac),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .OUT_FLOAT32 (OUT_FLOAT32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [7:0] i, input logic [22:0] f);
    @(negedge clk);
    chk("pre_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    IN_int   = i;
    IN_frac  = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_ovd"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag,
                     input logic [7:0] i, input logic [22:0] f,
                     input logic [31:0] exp_f, input int exp_lat);
    int n;
    accept(i, f);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_out"}, OUT_FLOAT32, exp_f);
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_out", OUT_FLOAT32, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("one",   8'h01, 23'h0, 32'h3F80_0000, 9);
    drain("one");
    run("mone",  8'hFF, 23'h0, 32'hBF80_0000, 9);
    drain("mone");
    run("zero",  8'h00, 23'h0, 32'h0000_0000, 2);
    drain("zero");
    run("m128",  8'h80, 23'h0, 32'hC300_0000, 2);
    drain("m128");
    run("lsb",   8'h00, 23'h1, 32'h3400_0000, 32);
    drain("lsb");
    run("two",   8'h02, 23'h0, 32'h4000_0000, 8);
    drain("two");
    run("3p5",   8'h03, 23'h40_0000, 32'h4060_0000, 8);
    drain("3p5");
    run("tie_even", 8'h40, 23'h20, 32'h4280_0000, 3);
    drain("tie_even");
`ifdef FIX2FLT_RNE_EN
    run("max",   8'h7F, 23'h7F_FFFF, 32'h4300_0000, 3);
    drain("max");
    run("sticky", 8'h40, 23'h30, 32'h4280_0001, 3);
    drain("sticky");
    run("tie_odd_neg", 8'hBF, 23'h7F_FFA0, 32'hC280_0002, 3);
    drain("tie_odd_neg");
`else
    run("max",   8'h7F, 23'h7F_FFFF, 32'h42FF_FFFF, 3);
    drain("max");
    run("sticky", 8'h40, 23'h30, 32'h4280_0000, 3);
    drain("sticky");
    run("tie_odd_neg", 8'hBF, 23'h7F_FFA0, 32'hC280_0001, 3);
    drain("tie_odd_neg");
`endif

    // Backpressure in DONE with ignored in_valid pulses.
    run("bp", 8'h01, 23'h0, 32'h3F80_0000, 9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      IN_int   = 8'h05;
      @(posedge clk);
      #1;
      chk("bp_out", OUT_FLOAT32, 32'h3F80_0000);
      chk("bp_ovd", 32'(out_valid), 32'd1);
      chk("bp_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_idle_ovd", 32'(out_valid), 32'd0);
    chk("bp_idle_rdy", 32'(in_ready), 32'd1);

    // Async reset mid-NORM.
    accept(8'h00, 23'h1);
    repeat (5) @(posedge clk);
    #2;
    chk("norm_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ovd", 32'(out_valid), 32'd0);
    chk("arst_out", OUT_FLOAT32, 32'h0);
    chk("arst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 8'hFE, 23'h0, 32'hC000_0000, 8);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
